vga_rect_fill_master: RTL and testbench
=======================================

// Module: vga_rect_fill_master
// PURPOSE
// Bus-master engine upstream of the VGA frame-buffer peripheral. It fills an axis-aligned
// rectangle with one pixel value by issuing, per pixel, bus writes to BASE+0 (X), BASE+1 (Y)
// and BASE+2 (pixel bit). It shares the 8-bit system bus with the processor through a
// REQ/GNT handshake and frees the CPU from per-pixel write loops.
// PARAMETERS
// VGABaseAddress  8'hB0  bus address of the X register; Y = +1, pixel = +2
// X_MAX           8'd159 largest legal X coordinate; larger values clamp to X_MAX
// Y_MAX           7'd119 largest legal Y coordinate; larger values clamp to Y_MAX
// PORTS
// CLK        in     1  system clock, 100 MHz
// RESET_N    in     1  asynchronous active-low reset
// START      in     1  one-cycle command strobe; sampled only in IDLE
// ABORT      in     1  stop after the current bus cycle; no DONE pulse
// X0, X1     in     8  rectangle corner X coordinates, in either order
// Y0, Y1     in     7  rectangle corner Y coordinates, in either order
// COLOUR     in     1  pixel value written at BASE+2 (BUS_DATA[0]); bits 7:1 driven 0
// BUS_GNT    in     1  bus grant from arbiter
// BUS_REQ    out    1  bus request
// BUS_ADDR   out    8  driven only while owning the bus, else 8'hZZ
// BUS_DATA   inout  8  driven only while owning the bus, else 8'hZZ
// BUS_WE     out    1  bus write strobe; 0 when not owning the bus
// BUSY       out    1  high in every state except IDLE
// DONE       out    1  one-cycle pulse after the last pixel write
// BEHAVIOUR
// - Reset (async, RESET_N=0): state IDLE; BUS_REQ=0, BUS_WE=0, BUSY=0, DONE=0, bus outputs Z,
//   all counters 0. Reset mid-fill abandons the fill with no further writes; resume is not supported.
// - Command latch (START=1 in IDLE): store xl=min(X0,X1), xh=max, yl=min(Y0,Y1), yh=max,
//   each clamped to X_MAX/Y_MAX; also store COLOUR; cx<=xl, cy<=yl. START outside IDLE is ignored.
//   Inputs may change after the START cycle.
// - States: IDLE -> REQ -> WR_X -> WR_Y -> WR_P -> (next pixel WR_X | FIN) ; FIN -> IDLE.
// - REQ: BUS_REQ=1, held until grant. BUS_REQ stays 1 from REQ through the last WR_P.
// - The engine owns the bus in any WR_* state while BUS_GNT=1. Registered outputs per state:
//   WR_X: ADDR=BASE, DATA=cx. WR_Y: ADDR=BASE+1, DATA={1'b0,cy}.
//   WR_P: ADDR=BASE+2, DATA={7'b0,colour}. BUS_WE=1 in each.
//   Each write completes in exactly 1 cycle, so a granted pixel takes 3 cycles.
// - Y is sent in raw frame coordinates; the VGA peripheral applies its own Y flip.
// - Scan order: X is the inner loop and Y the outer loop. After WR_P:
//   if cx<xh then cx+1; else if cy<yh then cx<=xl, cy+1; else FIN.
//   Pixel count = (xh-xl+1)*(yh-yl+1). Total cycles from first grant = 3*count + 1 when grant is uninterrupted.
// - Grant loss: if BUS_GNT=0 in a WR_* state, the engine drives the bus to Z with BUS_WE=0
//   and waits with BUS_REQ=1. When the grant returns, it restarts the current pixel at WR_X,
//   because another master may have overwritten the X/Y registers.
// - ABORT: honoured in any non-IDLE state. The in-flight write cycle completes, then the engine
//   goes to IDLE with the bus released and BUS_REQ=0. No DONE pulse. ABORT in IDLE has no effect.
// - FIN: BUS_REQ=0, bus released, DONE=1 for one cycle; then IDLE.
// - ABORT and last WR_P in the same cycle: ABORT wins and no DONE pulse is issued.
// - Degenerate rectangle (X0==X1, Y0==Y1): exactly one pixel is written.
// TESTING
// 1 GNT tied 1; START with X0=5,X1=5,Y0=7,Y1=7,COLOUR=1 -> writes B0=05, B1=07, B2=01;
//   DONE 1 cycle after B2; BUSY falls with DONE.
// 2 START with X0=11,X1=10,Y0=3,Y1=2 -> pixel order (10,2),(11,2),(10,3),(11,3);
//   12 write cycles, then DONE.
// 3 START with X0=200,Y0=127,X1=158,Y1=118 -> clamped to X 158..159, Y 118..119; no write exceeds 159/119.
// 4 Drop GNT for 5 cycles in WR_Y of pixel 2 -> bus Z and WE=0 during the gap;
//   on regrant, pixel 2 restarts at B0; total writes = 12+1.
// 5 Assert RESET_N=0 mid-fill -> bus Z, BUS_REQ=0, BUSY=0 immediately (async);
//   no writes after release until a new START.
// 6 ABORT during WR_X of pixel 3 of 4; START pulsed while BUSY -> that write completes, then IDLE;
//   no DONE; the mid-fill START is ignored.

Source files
------------

// File: rtl/vga_rect_fill_master_if.sv
// rtl/vga_rect_fill_master_if.sv - shared 8-bit system bus with request/grant handshake
//
// Purpose: groups the arbitration and tri-stated bus signals used by the rectangle
// fill engine (master) and the arbiter / frame-buffer side (slave).
// Signals:
//   BUS_REQ   master -> arbiter   bus request
//   BUS_GNT   arbiter -> master   bus grant
//   BUS_WE    master -> slave     write strobe, 0 whenever the master does not own the bus
//   BUS_ADDR  master -> slave     8-bit address, Z when the master does not own the bus
//   BUS_DATA  shared              8-bit data, Z when the master does not own the bus
interface vga_rect_fill_master_if;
  logic       BUS_REQ;
  logic       BUS_GNT;
  logic       BUS_WE;
  wire  [7:0] BUS_ADDR;
  wire  [7:0] BUS_DATA;

  modport master (
    output BUS_REQ,
    output BUS_WE,
    output BUS_ADDR,
    inout  BUS_DATA,
    input  BUS_GNT
  );

  modport slave (
    input  BUS_REQ,
    input  BUS_WE,
    input  BUS_ADDR,
    inout  BUS_DATA,
    output BUS_GNT
  );
endinterface

// File: rtl/vga_rect_fill_master.sv
// rtl/vga_rect_fill_master.sv - bus-master engine filling a rectangle in the VGA frame buffer
//
// Purpose: on START, latches an ordered and clamped rectangle plus a colour, then for every
// pixel (X inner loop, Y outer loop) writes X to BASE+0, Y to BASE+1 and the colour to
// BASE+2 over the shared bus, arbitrating with BUS_REQ/BUS_GNT.
// Ports:
//   CLK      in   system clock
//   RESET_N  in   asynchronous active-low reset
//   START    in   one-cycle command strobe, honoured only when idle
//   ABORT    in   finish the current bus cycle, then return to idle without DONE
//   X0, X1   in   8-bit corner X coordinates, any order
//   Y0, Y1   in   7-bit corner Y coordinates, any order
//   COLOUR   in   pixel value written to BASE+2
//   BUSY     out  high whenever not idle
//   DONE     out  one-cycle pulse after the last pixel write
//   bus      master side of the shared system bus
module vga_rect_fill_master #(
  parameter logic [7:0] VGABaseAddress = 8'hB0,
  parameter logic [7:0] X_MAX          = 8'd159,
  parameter logic [6:0] Y_MAX          = 7'd119
) (
  input  logic                          CLK,
  input  logic                          RESET_N,
  input  logic                          START,
  input  logic                          ABORT,
  input  logic [7:0]                    X0,
  input  logic [7:0]                    X1,
  input  logic [6:0]                    Y0,
  input  logic [6:0]                    Y1,
  input  logic                          COLOUR,
  output logic                          BUSY,
  output logic                          DONE,
  vga_rect_fill_master_if.master        bus
);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    REQ  = 3'd1,
    WR_X = 3'd2,
    WR_Y = 3'd3,
    WR_P = 3'd4,
    FIN  = 3'd5
  } state_t;

  state_t     state_q, state_d;
  logic [7:0] xl_q, xh_q, cx_q;
  logic [6:0] yl_q, yh_q, cy_q;
  logic       colour_q;

  logic [7:0] x_lo, x_hi;
  logic [6:0] y_lo, y_hi;
  logic       in_wr, own, last_px, px_done;
  logic [7:0] addr_d, data_d;

  // Order the corners, then clamp into the visible frame.
  always_comb begin
    x_lo = (X0 < X1) ? X0 : X1;
    x_hi = (X0 < X1) ? X1 : X0;
    y_lo = (Y0 < Y1) ? Y0 : Y1;
    y_hi = (Y0 < Y1) ? Y1 : Y0;
    if (x_lo > X_MAX) x_lo = X_MAX;
    if (x_hi > X_MAX) x_hi = X_MAX;
    if (y_lo > Y_MAX) y_lo = Y_MAX;
    if (y_hi > Y_MAX) y_hi = Y_MAX;
  end

  assign in_wr   = (state_q == WR_X) || (state_q == WR_Y) || (state_q == WR_P);
  // Ownership follows the grant combinationally so a revoked grant frees the bus at once.
  assign own     = in_wr && bus.BUS_GNT;
  assign last_px = (cx_q == xh_q) && (cy_q == yh_q);
  // A pixel is finished only when its colour write actually happened and was not aborted.
  assign px_done = (state_q == WR_P) && bus.BUS_GNT && !ABORT;

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (START) state_d = REQ;
      REQ: begin
        if (ABORT)            state_d = IDLE;
        else if (bus.BUS_GNT) state_d = WR_X;
      end
      WR_X: begin
        if (ABORT)             state_d = IDLE;
        else if (!bus.BUS_GNT) state_d = REQ;
        else                   state_d = WR_Y;
      end
      WR_Y: begin
        if (ABORT)             state_d = IDLE;
        else if (!bus.BUS_GNT) state_d = REQ;
        else                   state_d = WR_P;
      end
      WR_P: begin
        // Losing the grant sends us back through REQ, which restarts the pixel at WR_X:
        // another master may have rewritten the X/Y registers meanwhile.
        if (ABORT)             state_d = IDLE;
        else if (!bus.BUS_GNT) state_d = REQ;
        else if (last_px)      state_d = FIN;
        else                   state_d = WR_X;
      end
      FIN:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      xl_q     <= 8'd0;
      xh_q     <= 8'd0;
      cx_q     <= 8'd0;
      yl_q     <= 7'd0;
      yh_q     <= 7'd0;
      cy_q     <= 7'd0;
      colour_q <= 1'b0;
    end else if ((state_q == IDLE) && START) begin
      xl_q     <= x_lo;
      xh_q     <= x_hi;
      cx_q     <= x_lo;
      yl_q     <= y_lo;
      yh_q     <= y_hi;
      cy_q     <= y_lo;
      colour_q <= COLOUR;
    end else if (px_done && !last_px) begin
      if (cx_q < xh_q) begin
        cx_q <= cx_q + 8'd1;
      end else begin
        cx_q <= xl_q;
        cy_q <= cy_q + 7'd1;
      end
    end
  end

  always_comb begin
    addr_d = 8'h00;
    data_d = 8'h00;
    case (state_q)
      WR_X: begin
        addr_d = VGABaseAddress;
        data_d = cx_q;
      end
      WR_Y: begin
        addr_d = VGABaseAddress + 8'd1;
        data_d = {1'b0, cy_q};
      end
      WR_P: begin
        addr_d = VGABaseAddress + 8'd2;
        data_d = {7'b0, colour_q};
      end
      default: begin
        addr_d = 8'h00;
        data_d = 8'h00;
      end
    endcase
  end

  assign bus.BUS_ADDR = own ? addr_d : 8'hzz;
  assign bus.BUS_DATA = own ? data_d : 8'hzz;
  assign bus.BUS_WE   = own;
  assign bus.BUS_REQ  = (state_q == REQ) || in_wr;

  assign BUSY = (state_q != IDLE);
  assign DONE = (state_q == FIN);

endmodule

// File: tb/tb_vga_rect_fill_master.sv
// tb/tb_vga_rect_fill_master.sv - self-checking bench for the rectangle fill bus master
module tb_vga_rect_fill_master;
  localparam logic [7:0] BASE = 8'hB0;
  localparam int XMAX = 159;
  localparam int YMAX = 119;

  logic       CLK     = 1'b0;
  logic       RESET_N = 1'b0;
  logic       START   = 1'b0;
  logic       ABORT   = 1'b0;
  logic       COLOUR  = 1'b0;
  logic [7:0] X0      = 8'd0;
  logic [7:0] X1      = 8'd0;
  logic [6:0] Y0      = 7'd0;
  logic [6:0] Y1      = 7'd0;
  logic       BUSY;
  logic       DONE;

  vga_rect_fill_master_if bus ();

  vga_rect_fill_master #(
    .VGABaseAddress(BASE),
    .X_MAX(8'd159),
    .Y_MAX(7'd119)
  ) dut (
    .CLK(CLK),
    .RESET_N(RESET_N),
    .START(START),
    .ABORT(ABORT),
    .X0(X0),
    .X1(X1),
    .Y0(Y0),
    .Y1(Y1),
    .COLOUR(COLOUR),
    .BUSY(BUSY),
    .DONE(DONE),
    .bus(bus)
  );

  always #5 CLK = ~CLK;

  int n_checks = 0;
  int n_errors = 0;
  int cyc      = 0;

  always @(posedge CLK) cyc <= cyc + 1;

  // Reference model: the list of pixels still to be written, in scan order.
  int         exp_x[$];
  int         exp_y[$];
  logic       m_col     = 1'b0;
  int         m_phase   = 0;
  logic       done_due  = 1'b0;
  int         wr_count  = 0;
  int         done_cyc  = -1;
  logic [7:0] log_a[$];
  logic [7:0] log_d[$];
  int         log_c[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge CLK);
      #1;
    end
  endtask

  task automatic plan_fill(input logic [7:0] x0, input logic [7:0] x1,
                           input logic [6:0] y0, input logic [6:0] y1, input logic col);
    int xl, xh, yl, yh;
    xl = (x0 < x1) ? int'(x0) : int'(x1);
    xh = (x0 < x1) ? int'(x1) : int'(x0);
    yl = (y0 < y1) ? int'(y0) : int'(y1);
    yh = (y0 < y1) ? int'(y1) : int'(y0);
    if (xl > XMAX) xl = XMAX;
    if (xh > XMAX) xh = XMAX;
    if (yl > YMAX) yl = YMAX;
    if (yh > YMAX) yh = YMAX;
    exp_x.delete();
    exp_y.delete();
    m_phase = 0;
    m_col   = col;
    for (int y = yl; y <= yh; y++) begin
      for (int x = xl; x <= xh; x++) begin
        exp_x.push_back(x);
        exp_y.push_back(y);
      end
    end
  endtask

  // Called at posedge+1 with the engine idle; returns at posedge+1 of the REQ cycle.
  task automatic start_fill(input logic [7:0] x0, input logic [7:0] x1,
                            input logic [6:0] y0, input logic [6:0] y1, input logic col);
    log_a.delete();
    log_d.delete();
    log_c.delete();
    wr_count = 0;
    done_cyc = -1;
    plan_fill(x0, x1, y0, y1, col);
    X0 = x0;
    X1 = x1;
    Y0 = y0;
    Y1 = y1;
    COLOUR = col;
    START = 1'b1;
    step(1);
    START  = 1'b0;
    X0     = 8'hFF;
    X1     = 8'h00;
    Y0     = 7'h7F;
    Y1     = 7'h00;
    COLOUR = ~col;
  endtask

  task automatic wait_done(input int max_cyc);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < max_cyc; i++) begin
      @(negedge CLK);
      if (DONE === 1'b1) begin
        seen = 1'b1;
        break;
      end
    end
    chk("done_seen", 32'(seen), 32'd1);
  endtask

  // Compare process: every cycle out of reset, check writes, bus release and DONE timing.
  initial begin : cmp
    logic [7:0] ea, ed;
    int tx, ty;
    forever begin
      @(negedge CLK);
      if (!RESET_N) begin
        done_due = 1'b0;
      end else begin
        chk("done_timing", 32'(DONE), 32'(done_due));
        if (DONE === 1'b1) done_cyc = cyc;
        done_due = 1'b0;
        if (bus.BUS_GNT !== 1'b1) begin
          chk("we_without_gnt", 32'(bus.BUS_WE), 32'd0);
          chk("addr_released", 32'((bus.BUS_ADDR === BASE) || (bus.BUS_ADDR === BASE + 8'd1) ||
                                   (bus.BUS_ADDR === BASE + 8'd2)), 32'd0);
          m_phase = 0;
        end else if (bus.BUS_WE === 1'b1) begin
          wr_count++;
          log_a.push_back(bus.BUS_ADDR);
          log_d.push_back(bus.BUS_DATA);
          log_c.push_back(cyc);
          chk("write_expected", 32'(exp_x.size() != 0), 32'd1);
          if (exp_x.size() != 0) begin
            tx = exp_x[0];
            ty = exp_y[0];
            ea = BASE + m_phase[7:0];
            if (m_phase == 0)      ed = tx[7:0];
            else if (m_phase == 1) ed = {1'b0, ty[6:0]};
            else                   ed = {7'b0, m_col};
            chk("write_addr", 32'(bus.BUS_ADDR), 32'(ea));
            chk("write_data", 32'(bus.BUS_DATA), 32'(ed));
            m_phase++;
            if (m_phase == 3) begin
              m_phase = 0;
              void'(exp_x.pop_front());
              void'(exp_y.pop_front());
              if (exp_x.size() == 0) done_due = 1'b1;
            end
          end
        end
        if (ABORT === 1'b1) begin
          exp_x.delete();
          exp_y.delete();
          m_phase  = 0;
          done_due = 1'b0;
        end
      end
    end
  end

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: simulation did not complete, errors so far %0d", n_errors);
    $fatal(1, "watchdog");
  end

  initial begin : main
    int nb, snap, maxx, maxy;
    bus.BUS_GNT = 1'b0;
    #2;
    chk("rst_req", 32'(bus.BUS_REQ), 32'd0);
    chk("rst_we", 32'(bus.BUS_WE), 32'd0);
    chk("rst_busy", 32'(BUSY), 32'd0);
    chk("rst_done", 32'(DONE), 32'd0);
    chk("rst_addr_released", 32'(bus.BUS_ADDR === BASE), 32'd0);
    step(2);
    RESET_N = 1'b1;
    bus.BUS_GNT = 1'b1;
    step(2);

    // Single pixel, grant tied high.
    start_fill(8'd5, 8'd5, 7'd7, 7'd7, 1'b1);
    wait_done(20);
    chk("t1_busy_with_done", 32'(BUSY), 32'd1);
    @(negedge CLK);
    chk("t1_done_one_cycle", 32'(DONE), 32'd0);
    chk("t1_busy_falls", 32'(BUSY), 32'd0);
    @(posedge CLK);
    #1;
    chk("t1_writes", 32'(wr_count), 32'd3);
    if (log_a.size() == 3) begin
      chk("t1_a0", 32'(log_a[0]), 32'hB0);
      chk("t1_d0", 32'(log_d[0]), 32'h05);
      chk("t1_a1", 32'(log_a[1]), 32'hB1);
      chk("t1_d1", 32'(log_d[1]), 32'h07);
      chk("t1_a2", 32'(log_a[2]), 32'hB2);
      chk("t1_d2", 32'(log_d[2]), 32'h01);
      chk("t1_done_after_b2", 32'(done_cyc - log_c[2]), 32'd1);
    end

    // Reversed corners: 2x2 block scanned X-inner.
    start_fill(8'd11, 8'd10, 7'd3, 7'd2, 1'b0);
    wait_done(60);
    @(posedge CLK);
    #1;
    chk("t2_writes", 32'(wr_count), 32'd12);
    if (log_d.size() == 12) begin
      chk("t2_p1_x", 32'(log_d[0]), 32'd10);
      chk("t2_p1_y", 32'(log_d[1]), 32'd2);
      chk("t2_p2_x", 32'(log_d[3]), 32'd11);
      chk("t2_p2_y", 32'(log_d[4]), 32'd2);
      chk("t2_p3_x", 32'(log_d[6]), 32'd10);
      chk("t2_p3_y", 32'(log_d[7]), 32'd3);
      chk("t2_p4_x", 32'(log_d[9]), 32'd11);
      chk("t2_p4_y", 32'(log_d[10]), 32'd3);
      chk("t2_cycles", 32'(done_cyc - log_c[0]), 32'd12);
    end

    // Out-of-range corners clamp to the frame edge.
    start_fill(8'd200, 8'd158, 7'd127, 7'd118, 1'b1);
    wait_done(60);
    @(posedge CLK);
    #1;
    chk("t3_writes", 32'(wr_count), 32'd12);
    maxx = 0;
    maxy = 0;
    for (int i = 0; i < log_a.size(); i++) begin
      if (log_a[i] == BASE && int'(log_d[i]) > maxx) maxx = int'(log_d[i]);
      if (log_a[i] == BASE + 8'd1 && int'(log_d[i]) > maxy) maxy = int'(log_d[i]);
    end
    chk("t3_max_x", 32'(maxx), 32'd159);
    chk("t3_max_y", 32'(maxy), 32'd119);
    if (log_d.size() >= 2) begin
      chk("t3_first_x", 32'(log_d[0]), 32'd158);
      chk("t3_first_y", 32'(log_d[1]), 32'd118);
    end

    // Grant dropped for 5 cycles during the Y write of pixel 2.
    start_fill(8'd60, 8'd61, 7'd5, 7'd6, 1'b1);
    nb = 0;
    for (int i = 0; i < 40 && nb < 2; i++) begin
      step(1);
      if (bus.BUS_WE === 1'b1 && bus.BUS_ADDR === BASE + 8'd1) nb++;
    end
    chk("t4_found_wr_y", 32'(nb), 32'd2);
    bus.BUS_GNT = 1'b0;
    #1;
    chk("t4_we_dropped", 32'(bus.BUS_WE), 32'd0);
    step(1);
    chk("t4_req_held", 32'(bus.BUS_REQ), 32'd1);
    step(4);
    bus.BUS_GNT = 1'b1;
    wait_done(60);
    @(posedge CLK);
    #1;
    chk("t4_writes", 32'(wr_count), 32'd13);
    if (log_a.size() >= 5) begin
      chk("t4_restart_addr", 32'(log_a[4]), 32'hB0);
      chk("t4_restart_x", 32'(log_d[4]), 32'd61);
    end

    // Asynchronous reset in the middle of a fill.
    start_fill(8'd20, 8'd21, 7'd30, 7'd31, 1'b0);
    for (int i = 0; i < 40 && wr_count < 4; i++) step(1);
    chk("t5_mid_fill", 32'(wr_count), 32'd4);
    #2;
    RESET_N = 1'b0;
    #1;
    chk("t5_req", 32'(bus.BUS_REQ), 32'd0);
    chk("t5_busy", 32'(BUSY), 32'd0);
    chk("t5_we", 32'(bus.BUS_WE), 32'd0);
    chk("t5_addr_released", 32'(bus.BUS_ADDR === BASE + 8'd1), 32'd0);
    exp_x.delete();
    exp_y.delete();
    m_phase = 0;
    snap = wr_count;
    @(posedge CLK);
    #1;
    step(1);
    RESET_N = 1'b1;
    step(10);
    chk("t5_no_writes_after", 32'(wr_count), 32'(snap));
    chk("t5_idle_after", 32'(BUSY), 32'd0);

    // ABORT (with a stray START) during the X write of pixel 3 of 4.
    start_fill(8'd40, 8'd41, 7'd50, 7'd51, 1'b1);
    nb = 0;
    for (int i = 0; i < 40 && nb < 3; i++) begin
      step(1);
      if (bus.BUS_WE === 1'b1 && bus.BUS_ADDR === BASE) nb++;
    end
    chk("t6_found_wr_x", 32'(nb), 32'd3);
    ABORT = 1'b1;
    START = 1'b1;
    X0 = 8'd0;
    X1 = 8'd3;
    Y0 = 7'd0;
    Y1 = 7'd3;
    step(1);
    ABORT = 1'b0;
    START = 1'b0;
    chk("t6_busy", 32'(BUSY), 32'd0);
    chk("t6_req", 32'(bus.BUS_REQ), 32'd0);
    step(10);
    chk("t6_writes", 32'(wr_count), 32'd7);
    chk("t6_no_done", 32'(done_cyc), 32'hFFFF_FFFF);
    chk("t6_still_idle", 32'(BUSY), 32'd0);
    if (log_d.size() >= 7) chk("t6_last_x", 32'(log_d[6]), 32'd40);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
